// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direction + target predictor for the 5-stage pipeline. Fetch looks up F_PC
// combinationally in the same cycle. Resolved branches and jumps come back
// through the U_* port and train the BTB and the counter table. GHIST_W = 0
// gives a bimodal predictor. GHIST_W > 0 gives gshare with a speculatively
// shifted global history register.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int GHIST_W = 0
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic [PC_W-1:0]                          F_PC,
    input  logic                                     F_ADV,
    output logic                                     F_HIT,
    output logic                                     F_PRED_TAKEN,
    output logic [PC_W-1:0]                          F_PRED_TGT,
    output logic [((GHIST_W > 0) ? GHIST_W : 1)-1:0] F_GHR,
    input  logic                                     U_V,
    input  logic [PC_W-1:0]                          U_PC,
    input  logic                                     U_IS_BR,
    input  logic                                     U_TAKEN,
    input  logic [PC_W-1:0]                          U_TGT,
    input  logic [((GHIST_W > 0) ? GHIST_W : 1)-1:0] U_GHR,
    input  logic                                     U_MISPRED
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int GH_W  = (GHIST_W > 0) ? GHIST_W : 1;

    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX     = CTR_W'((2 ** CTR_W) - 1);
    localparam logic [CTR_W-1:0] CTR_ZERO    = CTR_W'(0);
    localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
    localparam logic [IDX_W-1:0] GH_MASK     = IDX_W'((2 ** GHIST_W) - 1);
    localparam logic [PC_W-1:0]  PC_STEP     = PC_W'(4);

    // Saturating increment of a direction counter.
    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : (c + CTR_ONE);
    endfunction

    // Saturating decrement of a direction counter.
    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (c == CTR_ZERO) ? c : (c - CTR_ONE);
    endfunction

    // History folded into the counter index. The mask is all-zero in bimodal
    // mode, so the history never perturbs the index there.
    function automatic logic [IDX_W-1:0] ghr_fold(input logic [GH_W-1:0] g);
        return IDX_W'(g) & GH_MASK;
    endfunction

    // Storage (flops, so a single reset assertion clears everything).
    logic             valid_r [ENTRIES];
    logic [TAG_W-1:0] tag_r   [ENTRIES];
    logic [PC_W-1:0]  tgt_r   [ENTRIES];
    logic             jmp_r   [ENTRIES];
    logic [CTR_W-1:0] ctr_r   [ENTRIES];
    logic [GH_W-1:0]  ghr_r;

    logic [IDX_W-1:0] f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    logic [IDX_W-1:0] f_cidx_s;
    logic             f_hit_s;
    logic             f_taken_s;
    logic [PC_W-1:0]  f_tgt_s;
    logic [IDX_W-1:0] u_idx_s;
    logic [TAG_W-1:0] u_tag_s;
    logic [IDX_W-1:0] u_cidx_s;
    logic             btb_we_s;
    logic             ctr_we_s;
    logic [CTR_W-1:0] ctr_nxt_s;
    logic [GH_W-1:0]  ghr_nxt_s;
    logic             unused_ok_s;

    // Byte-offset bits of the update PC carry no information.
    assign unused_ok_s = ^U_PC[1:0];

    // Fetch-side field extraction.
    assign f_idx_s  = F_PC[IDX_W+1:2];
    assign f_tag_s  = F_PC[PC_W-1:IDX_W+2];
    assign f_cidx_s = f_idx_s ^ ghr_fold(ghr_r);

    // Update-side field extraction.
    assign u_idx_s  = U_PC[IDX_W+1:2];
    assign u_tag_s  = U_PC[PC_W-1:IDX_W+2];
    assign u_cidx_s = u_idx_s ^ ghr_fold(U_GHR);

    // Zero-latency lookup; a same-cycle update is not bypassed.
    always_comb begin
        f_hit_s   = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        f_taken_s = f_hit_s && (jmp_r[f_idx_s] || ctr_r[f_cidx_s][CTR_W-1]);
        if (f_taken_s) begin
            f_tgt_s = tgt_r[f_idx_s];
        end else begin
            f_tgt_s = F_PC + PC_STEP;
        end
    end

    assign F_HIT        = f_hit_s;
    assign F_PRED_TAKEN = f_taken_s;
    assign F_PRED_TGT   = f_tgt_s;
    assign F_GHR        = ghr_r;

    // Write enables and next counter value for the resolved instruction.
    always_comb begin
        btb_we_s = U_V && U_TAKEN;
        ctr_we_s = U_V && U_IS_BR;
        if (U_TAKEN) begin
            ctr_nxt_s = ctr_inc(ctr_r[u_cidx_s]);
        end else begin
            ctr_nxt_s = ctr_dec(ctr_r[u_cidx_s]);
        end
    end

    // Next global history: a redirect repairs it, otherwise fetch shifts it
    // speculatively on a predicted conditional branch.
    always_comb begin
        ghr_nxt_s = ghr_r;
        if (GHIST_W == 0) begin
            ghr_nxt_s = '0;
        end else if (U_V && U_MISPRED) begin
            if (U_IS_BR) begin
                ghr_nxt_s = (U_GHR << 1'b1) | GH_W'(U_TAKEN);
            end else begin
                ghr_nxt_s = U_GHR;
            end
        end else if (F_ADV && f_hit_s && !jmp_r[f_idx_s]) begin
            ghr_nxt_s = (ghr_r << 1'b1) | GH_W'(f_taken_s);
        end else begin
            ghr_nxt_s = ghr_r;
        end
    end

    // BTB: taken instructions allocate or overwrite their slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= '0;
                tgt_r[i]   <= '0;
                jmp_r[i]   <= 1'b0;
            end
        end else if (btb_we_s) begin
            valid_r[u_idx_s] <= 1'b1;
            tag_r[u_idx_s]   <= u_tag_s;
            tgt_r[u_idx_s]   <= U_TGT;
            jmp_r[u_idx_s]   <= !U_IS_BR;
        end else begin
            valid_r[u_idx_s] <= valid_r[u_idx_s];
        end
    end

    // Direction counters: only conditional branches train them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CTR_WEAK_NT;
            end
        end else if (ctr_we_s) begin
            ctr_r[u_cidx_s] <= ctr_nxt_s;
        end else begin
            ctr_r[u_cidx_s] <= ctr_r[u_cidx_s];
        end
    end

    // Global history register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ghr_r <= '0;
        end else begin
            ghr_r <= ghr_nxt_s;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench: a bimodal instance (defaults) and a gshare instance
// (GHIST_W=4) share clock, reset, fetch and update stimulus; only the
// history inputs differ. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        CLK;
    logic        RST_N;
    logic [15:0] f_pc;
    logic        f_adv;
    logic        u_v;
    logic [15:0] u_pc;
    logic        u_is_br;
    logic        u_taken;
    logic [15:0] u_tgt;
    logic        u_mispred;
    logic        u_ghr_b;
    logic [3:0]  u_ghr_g;

    logic        b_hit, b_taken;
    logic [15:0] b_tgt;
    logic        b_ghr;
    logic        g_hit, g_taken;
    logic [15:0] g_tgt;
    logic [3:0]  g_ghr;

    int cmp_cnt;
    int err_cnt;

    branch_predictor dut (
        .CLK(CLK), .RST_N(RST_N), .F_PC(f_pc), .F_ADV(f_adv),
        .F_HIT(b_hit), .F_PRED_TAKEN(b_taken), .F_PRED_TGT(b_tgt), .F_GHR(b_ghr),
        .U_V(u_v), .U_PC(u_pc), .U_IS_BR(u_is_br), .U_TAKEN(u_taken),
        .U_TGT(u_tgt), .U_GHR(u_ghr_b), .U_MISPRED(u_mispred)
    );

    branch_predictor #(.GHIST_W(4)) dut_g (
        .CLK(CLK), .RST_N(RST_N), .F_PC(f_pc), .F_ADV(f_adv),
        .F_HIT(g_hit), .F_PRED_TAKEN(g_taken), .F_PRED_TGT(g_tgt), .F_GHR(g_ghr),
        .U_V(u_v), .U_PC(u_pc), .U_IS_BR(u_is_br), .U_TAKEN(u_taken),
        .U_TGT(u_tgt), .U_GHR(u_ghr_g), .U_MISPRED(u_mispred)
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        cmp_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle update pulse (no mispredict).
    task automatic upd(input logic [15:0] pc, input logic br, input logic tk, input logic [15:0] tgt);
        u_v = 1'b1; u_pc = pc; u_is_br = br; u_taken = tk; u_tgt = tgt; u_mispred = 1'b0;
        tick();
        u_v = 1'b0;
    endtask

    task automatic look_b(input string tag, input logic [15:0] pc,
                          input logic hit, input logic tk, input logic [15:0] tgt);
        f_pc = pc;
        #1;
        check_val({tag, "_hit"}, {31'd0, b_hit}, {31'd0, hit});
        check_val({tag, "_taken"}, {31'd0, b_taken}, {31'd0, tk});
        check_val({tag, "_tgt"}, {16'd0, b_tgt}, {16'd0, tgt});
    endtask

    initial begin
        cmp_cnt = 0; err_cnt = 0;
        RST_N = 1'b0; f_pc = 16'h0040; f_adv = 1'b0;
        u_v = 1'b0; u_pc = 16'h0000; u_is_br = 1'b0; u_taken = 1'b0;
        u_tgt = 16'h0000; u_mispred = 1'b0; u_ghr_b = 1'b0; u_ghr_g = 4'b0000;

        // 1: reset state
        #1;
        look_b("t1_rst", 16'h0040, 1'b0, 1'b0, 16'h0044);
        check_val("t1_ghr_g", {28'd0, g_ghr}, 32'd0);
        check_val("t1_ghr_b", {31'd0, b_ghr}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // 2: taken branch update; same-cycle lookup still sees the empty slot
        u_v = 1'b1; u_pc = 16'h0040; u_is_br = 1'b1; u_taken = 1'b1; u_tgt = 16'h0010;
        #1;
        check_val("t2_nobypass", {31'd0, b_hit}, 32'd0);
        tick();
        u_v = 1'b0;
        look_b("t2_after", 16'h0040, 1'b1, 1'b1, 16'h0010);

        // 3: saturation at 3, then decrement down to not-taken
        for (int i = 0; i < 4; i++) upd(16'h0040, 1'b1, 1'b1, 16'h0010);
        upd(16'h0040, 1'b1, 1'b0, 16'h0000);
        look_b("t3_sat", 16'h0040, 1'b1, 1'b1, 16'h0010);
        upd(16'h0040, 1'b1, 1'b0, 16'h0000);
        upd(16'h0040, 1'b1, 1'b0, 16'h0000);
        look_b("t3_nt", 16'h0040, 1'b1, 1'b0, 16'h0044);

        // 4: alias on the same index with a different tag
        look_b("t4_alias_miss", 16'h0140, 1'b0, 1'b0, 16'h0144);
        upd(16'h0140, 1'b1, 1'b1, 16'h0200);
        look_b("t4_evicted", 16'h0040, 1'b0, 1'b0, 16'h0044);
        look_b("t4_new", 16'h0140, 1'b1, 1'b0, 16'h0144);

        // 5: JAL predicts taken and leaves its counter alone
        upd(16'h0080, 1'b0, 1'b1, 16'h0100);
        look_b("t5_jal", 16'h0080, 1'b1, 1'b1, 16'h0100);
        upd(16'h0080, 1'b1, 1'b1, 16'h0100);
        upd(16'h0080, 1'b1, 1'b0, 16'h0000);
        look_b("t5_ctr", 16'h0080, 1'b1, 1'b0, 16'h0084);

        // 6: gshare history; train ctr[48] (ghr=0) and ctr[49] (ghr=1)
        u_ghr_g = 4'b0000;
        upd(16'h00C0, 1'b1, 1'b1, 16'h0300);
        u_ghr_g = 4'b0001;
        upd(16'h00C0, 1'b1, 1'b1, 16'h0300);
        u_ghr_g = 4'b0000;
        f_pc = 16'h00C0; f_adv = 1'b1;
        #1;
        check_val("t6_ghr0", {28'd0, g_ghr}, 32'd0);
        check_val("t6_taken0", {31'd0, g_taken}, 32'd1);
        tick();
        check_val("t6_ghr1", {28'd0, g_ghr}, 32'd1);
        check_val("t6_taken1", {31'd0, g_taken}, 32'd1);
        tick();
        check_val("t6_ghr2", {28'd0, g_ghr}, 32'b0011);
        u_v = 1'b1; u_mispred = 1'b1; u_is_br = 1'b1; u_taken = 1'b1;
        u_pc = 16'h00C0; u_tgt = 16'h0300; u_ghr_g = 4'b0101;
        tick();
        check_val("t6_repair", {28'd0, g_ghr}, 32'b1011);
        f_adv = 1'b0; u_is_br = 1'b0; u_ghr_g = 4'b0110;
        tick();
        u_v = 1'b0; u_mispred = 1'b0; u_ghr_g = 4'b0000;
        check_val("t6_jal_repair", {28'd0, g_ghr}, 32'b0110);
        f_adv = 1'b1;
        tick();
        f_adv = 1'b0;
        check_val("t6_jump_hold", {28'd0, g_ghr}, 32'b0110);
        check_val("t6_jump_taken", {31'd0, g_taken}, 32'd1);
        check_val("t6_jump_tgt", {16'd0, g_tgt}, 32'h0300);

        // 7: asynchronous reset mid-cycle discards the pending update
        u_v = 1'b1; u_pc = 16'h0200; u_is_br = 1'b1; u_taken = 1'b1; u_tgt = 16'h0400;
        f_pc = 16'h00C0;
        #2;
        RST_N = 1'b0;
        #1;
        check_val("t7_hit", {31'd0, b_hit}, 32'd0);
        check_val("t7_tgt", {16'd0, b_tgt}, 32'h00C4);
        check_val("t7_ghr_g", {28'd0, g_ghr}, 32'd0);
        tick();
        RST_N = 1'b1;
        u_v = 1'b0;
        look_b("t7_no_upd", 16'h0200, 1'b0, 1'b0, 16'h0204);
        tick();
        look_b("t7_still_empty", 16'h0040, 1'b0, 1'b0, 16'h0044);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
